// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant and bounded hold time.
// HOLD_MAX caps consecutive grant cycles per requester; 0 disables the cap.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Req,
    output logic [7:0] Gnt,
    output logic [2:0] GntIdx,
    output logic       Valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] idx_nxt;
    logic [7:0] gnt_nxt;
    logic       valid_nxt;
    logic [7:0] hold_cnt, hold_nxt;

    logic [2:0] scan_base;
    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_found;
    logic       hold_hit;
    logic       rel;

    // While granting, the scan base is the post-release pointer (GntIdx+1),
    // so a same-edge handover sees the updated priority.
    always_comb begin
        scan_base = (state == GRANT) ? GntIdx + 3'd1 : ptr;
        cand      = '0;
        win_idx   = scan_base;
        win_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = scan_base + 3'(i);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        hold_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
        rel      = !Req[GntIdx] || hold_hit;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = GntIdx;
        gnt_nxt   = Gnt;
        valid_nxt = Valid;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = GRANT;
                    idx_nxt   = win_idx;
                    gnt_nxt   = 8'd1 << win_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!rel) begin
                    if (hold_cnt != '1) begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end else begin
                    ptr_nxt = GntIdx + 3'd1;
                    if (win_found) begin
                        idx_nxt  = win_idx;
                        gnt_nxt  = 8'd1 << win_idx;
                        hold_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            ptr      <= '0;
            GntIdx   <= '0;
            Gnt      <= '0;
            Valid    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            GntIdx   <= idx_nxt;
            Gnt      <= gnt_nxt;
            Valid    <= valid_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- Internally encodes the winner as a 3-bit index and emits a one-hot grant, which is the 3-to-8 decode of that index.
- Sits in front of any shared datapath selected by a one-hot enable. Guarantees fairness and a bounded hold time per requester.

Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one requester may hold the grant. 0 means unlimited. Legal range 0..255.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  8  request vector; Req[i]=1 means requester i wants the resource.
- Gnt  output  8  registered one-hot grant, or all-zero when idle. Gnt == (Valid ? 1<<GntIdx : 0).
- GntIdx  output  3  binary index of the current grantee. Holds its last value when idle.
- Valid  output  1  registered; 1 while a grant is active.

Behaviour:
- Reset (asynchronous, Rst=1):
  - State=IDLE, Gnt=8'h00, GntIdx=0, Valid=0.
  - Priority pointer Ptr=0, HoldCnt=0.
  - Takes effect immediately, including mid-grant. Outputs return to reset values without waiting for a clock edge.
- Winner selection (combinational):
  - Scan Req starting at Ptr, increasing index, wrapping 7->0.
  - The first set bit wins.
  - Ptr is always (last grantee + 1) mod 8. Its value after reset is 0.
- State IDLE:
  - Gnt=0, Valid=0.
  - If Req != 0 at a rising edge: go to GRANT, GntIdx<=winner, Gnt<=one-hot(winner), Valid<=1, HoldCnt<=0.
  - Latency from Req asserting to Gnt is 1 clock.
- State GRANT, evaluated each rising edge:
  - Release occurs when Req[GntIdx]=0, or when HOLD_MAX!=0 and HoldCnt==HOLD_MAX-1.
  - No release: stay in GRANT, HoldCnt<=HoldCnt+1 (saturating at 255 when HOLD_MAX=0), Gnt unchanged.
  - On release: Ptr<=GntIdx+1 (mod 8). Then select a winner from the current Req, scanning from the new Ptr.
  - On a Req[GntIdx]=0 release, the old grantee's bit is 0, so it cannot re-win.
  - If a winner exists: stay in GRANT, load the new GntIdx/Gnt, HoldCnt<=0. The handover is back-to-back with no idle cycle.
  - If there is no winner: go to IDLE, Gnt<=0, Valid<=0. GntIdx keeps its old value.
- Timeout with the grantee as the only requester: the scan wraps back to the same index. The grantee is re-granted with HoldCnt reset and Valid staying 1.
- Requests that assert or deassert for non-granted indices while in GRANT have no effect until the next release.
- Simultaneous release and new requests: the new Req value sampled at that same edge participates in selection.
- Invariant: Gnt is never multi-hot. Gnt!=0 if and only if Valid=1.
- Gnt depends only on registers; there is no combinational path from Req to Gnt.

Test Plan:
- Reset while Req=8'hFF, then release Rst -> Gnt=8'h00 during reset; 1 clock after release Gnt=8'h01, GntIdx=0, Valid=1.
- Req=8'hFF held, HOLD_MAX=4 -> each requester holds exactly 4 cycles; grants rotate 01,02,04,...,80,01 with no idle cycle between them.
- Req=8'h24 (requesters 2 and 5). Drop bit 2 after 3 cycles of grant -> Gnt goes 04 then 20 on the next edge. When bit 5 also drops -> Gnt=00, Valid=0, GntIdx stays 5.
- Req=8'h08 only, HOLD_MAX=4, held 12 cycles -> Gnt=08 throughout, Valid never drops, HoldCnt reloads every 4 cycles.
- HOLD_MAX=0, Req=8'h81 -> requester 0 keeps the grant for 300+ cycles; drop bit 0 -> Gnt=80 on the next edge.
- Assert Rst asynchronously mid-grant (between edges) with Gnt=8'h10 -> Gnt=00 and Valid=0 immediately. After release with Req=8'h10 -> Gnt=10 in 1 clock (Ptr restarted at 0).
